varredor_canais: RTL
====================

VARREDOR_CANAIS -- requirements
Module: varredor_canais

Interface
REQ-001 SHALL have parameter DWELL_W, default 4, width of dwell-count input.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-004 SHALL have port en, input, 1, scan enable.
REQ-005 SHALL have port mask, input, 4, per-channel enable (bit n = channel n).
REQ-006 SHALL have port dwell, input, DWELL_W, extra hold cycles per channel.
REQ-007 SHALL have port A, output, 1, mux select MSB (channel bit 1: pair I0/I1 vs I2/I3).
REQ-008 SHALL have port B, output, 1, mux select LSB (channel bit 0: within pair).
REQ-009 SHALL have port valid, output, 1, high while {A,B} addresses an active scan slot.
REQ-010 SHALL have port frame, output, 1, one-cycle pulse on first cycle of each new scan round.

Function
REQ-011 SHALL implement FSM with states IDLE and SCAN; A, B, valid, frame all registered.
REQ-012 IDLE -> SCAN SHALL occur when en=1 and mask!=0; next cycle {A,B}=lowest enabled channel, valid=1, frame=1.
REQ-013 In SCAN each channel SHALL be held for dwell+1 cycles; dwell sampled on the channel's first cycle, later changes ignored until next channel.
REQ-014 On hold expiry SHALL advance to next enabled channel in circular order n+1, n+2, ... (mod 4).
REQ-015 frame SHALL pulse 1 cycle when the advance wraps (new channel index <= old index), including single-channel mask re-entering itself.
REQ-016 mask changes SHALL take effect only at the next advance; a current channel cleared mid-hold completes its hold.
REQ-017 en=0 in SCAN SHALL return to IDLE next cycle: valid=0, frame=0, {A,B} hold last value, dwell counter cleared.
REQ-018 mask=0 at an advance SHALL return to IDLE (valid=0, {A,B} held); IDLE with mask=0 SHALL stay IDLE regardless of en.
REQ-019 en re-asserted after IDLE SHALL restart from lowest enabled channel with frame=1 (no resume).
REQ-020 Dwell counter SHALL be DWELL_W bits, count up from 0, compare to sampled dwell; no overflow possible.
REQ-021 rst SHALL take priority over en, mask, and all FSM transitions.

Reset
REQ-022 On rst=1 at clock edge: state=IDLE, A=0, B=0, valid=0, frame=0, dwell counter=0.
REQ-023 rst asserted mid-hold SHALL abort the slot; first cycle after rst release with en=1 SHALL still be IDLE, SCAN entry the cycle after.

Configuration
REQ-024 With VARREDOR_MASK_EN defined, mask skipping SHALL behave per REQ-012..REQ-018.
REQ-025 Without VARREDOR_MASK_EN, mask SHALL be ignored (treated as 4'b1111): scan 0,1,2,3,0,... from channel 0; the mask=0 rules of REQ-018 do not apply.

Structure
REQ-026 Shared package varredor_pkg SHALL hold state enum (IDLE, SCAN), constant NUM_CANAIS=4, default DWELL_W=4.
REQ-027 Next-enabled-channel search SHALL be a combinational sub-module proximo_canal (inputs current channel, mask; outputs next channel, wrap flag, none flag).

Verification
REQ-028 rst, mask=4'b1111, dwell=0, en=1 -> {A,B}=0,1,2,3,0 on consecutive cycles; valid=1; frame=1 on each channel-0 cycle.
REQ-029 mask=4'b1010, dwell=2 -> channel 1 for 3 cycles, channel 3 for 3 cycles, channel 1 with frame=1.
REQ-030 dwell=3 then changed to 0 mid-hold of channel 0 -> channel 0 held 4 cycles, following channels 1 cycle each.
REQ-031 Scanning at channel 2, en=0 one cycle -> valid=0, {A,B}=2 held; en=1 again -> lowest enabled channel, frame=1.
REQ-032 mask cleared to 0 during hold of channel 1 (dwell=1) -> channel 1 completes 2 cycles, then valid=0 and IDLE.
REQ-033 rst pulsed mid-hold of channel 3 -> next cycle A=0, B=0, valid=0; both macro settings run with REQ-028 stimulus.

Source files
------------

// File: rtl/varredor_pkg.sv
// Shared types and constants for the four-channel mux scanner.
package varredor_pkg;
    localparam int NUM_CANAIS  = 4;
    localparam int DWELL_W_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } estado_e;
endpackage

// File: rtl/varredor_canais_if.sv
// Control/select bundle between a scan controller host and the varredor_canais scanner.
interface varredor_canais_if
    import varredor_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
);
    logic                  en;
    logic [NUM_CANAIS-1:0] mask;
    logic [DWELL_W-1:0]    dwell;
    logic                  A;
    logic                  B;
    logic                  valid;
    logic                  frame;

    modport master (output en, mask, dwell, input A, B, valid, frame);
    modport slave  (input en, mask, dwell, output A, B, valid, frame);
endinterface

// File: rtl/proximo_canal.sv
// Combinational search for the next enabled channel after cur_i, in circular order.
module proximo_canal
    import varredor_pkg::*;
(
    input  logic [1:0]            cur_i,
    input  logic [NUM_CANAIS-1:0] mask_i,
    output logic [1:0]            nxt_o,
    output logic                  wrap_o,
    output logic                  none_o
);
    logic       found;
    logic [1:0] idx;

    always_comb begin
        nxt_o = cur_i;
        found = 1'b0;
        idx   = cur_i;
        // Offset 4 lands back on cur_i, so a lone enabled channel re-selects itself.
        for (int i = 1; i <= NUM_CANAIS; i++) begin
            idx = cur_i + 2'(i);
            if (!found && mask_i[idx]) begin
                nxt_o = idx;
                found = 1'b1;
            end
        end
        none_o = (mask_i == '0);
        wrap_o = found && (nxt_o <= cur_i);
    end
endmodule

// File: rtl/varredor_canais.sv
// Analog-mux channel scanner: holds each enabled channel dwell+1 cycles, pulses frame per round.
// Define VARREDOR_MASK_EN to honour the per-channel mask; otherwise all four channels scan.
module varredor_canais
    import varredor_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    varredor_canais_if.slave  bus
);
    estado_e               state_q;
    logic [1:0]            ch_q;
    logic                  valid_q;
    logic                  frame_q;
    logic [DWELL_W-1:0]    cnt_q;
    logic [DWELL_W-1:0]    dwell_q;

    logic [NUM_CANAIS-1:0] mask_eff;
    logic [1:0]            cur_sel;
    logic [1:0]            nxt;
    logic                  wrap;
    logic                  none;
    logic [DWELL_W-1:0]    lim;

`ifdef VARREDOR_MASK_EN
    assign mask_eff = bus.mask;
`else
    logic unused_mask;
    assign unused_mask = ^bus.mask;
    assign mask_eff    = '1;
`endif

    // Searching from channel 3 while idle yields the lowest enabled channel.
    assign cur_sel = (state_q == IDLE) ? 2'd3 : ch_q;

    proximo_canal u_prox (
        .cur_i  (cur_sel),
        .mask_i (mask_eff),
        .nxt_o  (nxt),
        .wrap_o (wrap),
        .none_o (none)
    );

    // On a channel's first cycle the live dwell applies; afterwards the sampled copy.
    assign lim = (cnt_q == '0) ? bus.dwell : dwell_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    frame_q <= 1'b0;
                    cnt_q   <= '0;
                    if (bus.en && !none) begin
                        state_q <= SCAN;
                        ch_q    <= nxt;
                        valid_q <= 1'b1;
                        frame_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        frame_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        if (cnt_q == '0)
                            dwell_q <= bus.dwell;
                        if (cnt_q == lim) begin
                            cnt_q <= '0;
                            if (none) begin
                                state_q <= IDLE;
                                valid_q <= 1'b0;
                                frame_q <= 1'b0;
                            end else begin
                                ch_q    <= nxt;
                                frame_q <= wrap;
                            end
                        end else begin
                            cnt_q   <= cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
                            frame_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.A     = ch_q[1];
    assign bus.B     = ch_q[0];
    assign bus.valid = valid_q;
    assign bus.frame = frame_q;
endmodule
